uart_rx_fifo: RTL

Parametrised next-generation UART receiver: 2-flop input synchroniser, glitch-rejecting start detection, mid-bit sampling FSM, configurable data width/parity/stop bits, and a show-ahead receive FIFO with per-entry error flags.
Replaces the single-entry receive path in the serial peripheral.
Reads one start bit, DATA_BITS data bits LSB-first, an optional parity bit, and STOP_BITS stop bits.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/rx_fifo.sv | 71 +++++++
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM states, the
// FIFO entry record and the parity function.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  // Data is sized for the widest legal frame and zero-padded for narrower ones.
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     perr;
    logic                     ferr;
  } rx_entry_t;

  // Zero padding does not disturb the XOR, so any DATA_BITS fits here.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead circular FIFO: the head entry is read combinationally from
// storage, pops and pushes take effect on the clock edge.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the head slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every always_comb output gets a default first, so no path can hold
  // a stale value and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking is reserved for always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates what is visible,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: input synchroniser, glitch-rejecting start detect, mid-bit
// sampling FSM and a show-ahead receive FIFO with per-entry error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          data_read,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          data_ready,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          overrun_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [TMR_W-1:0] HALF_RELOAD = TMR_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [TMR_W-1:0] FULL_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP   = 1'(STOP_BITS - 1);
  localparam logic             ODD_PARITY  = (PARITY_ODD != 0);

  logic sync1_q, sync2_q, s_prev_q;
  logic s_in;

  rx_state_t            state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic      sample;
  logic      frame_done;
  logic      push;
  rx_entry_t push_entry;
  rx_entry_t head_entry;
  logic      fifo_empty, fifo_full;

  assign s_in = sync2_q;

  // Synchroniser idles high so a reset never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      sync1_q  <= serial_in;
      sync2_q  <= sync1_q;
      s_prev_q <= sync2_q;
    end
  end

  assign sample = (timer_q == '0);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;

    if (state_q inside {START, DATA, PARITY, STOP}) begin
      timer_d = sample ? FULL_RELOAD : timer_q - TMR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (s_prev_q && !s_in) begin
          state_d    = START;
          timer_d    = HALF_RELOAD;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      START: begin
        if (sample) state_d = s_in ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d = {s_in, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (sample) begin
          perr_d  = (parity_of(MAX_DATA_BITS'(shift_q)) ^ s_in) != ODD_PARITY;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          ferr_d = ferr_q | ~s_in;
          if (stop_idx_q == LAST_STOP) begin
            frame_done = 1'b1;
            state_d    = s_in ? IDLE : BREAK_WAIT;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      BREAK_WAIT: begin
        if (s_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final stop sample is folded in directly so the push happens on that edge.
  always_comb begin
    push_entry.data = MAX_DATA_BITS'(shift_q);
    push_entry.perr = perr_q;
    push_entry.ferr = ferr_q | ~s_in;
  end

  assign push = frame_done && (!fifo_full || data_read);

  always_comb begin
    overrun_d = overrun_q;
    if (frame_done && !push)          overrun_d = 1'b1;
    else if (data_read && !fifo_empty) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  rx_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (data_read),
    .data_o  (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign data_ready    = !fifo_empty;
  assign rx_data       = fifo_empty ? '0 : DATA_BITS'(head_entry.data);
  assign parity_error  = !fifo_empty && head_entry.perr;
  assign framing_error = !fifo_empty && head_entry.ferr;
  assign overrun_error = overrun_q;
  assign rx_busy       = (state_q != IDLE);

endmodule
